// File: rtl/uart_rx_cfg_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned BIT_MIN = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_PUSH,
    ST_BRK_WAIT
  } rx_state_t;

  typedef struct packed {
    logic [3:0] bits;
    logic [1:0] parity;
    logic       stop2;
  } rx_cfg_t;

  // Encoding 2'b11 is treated as "no parity".
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with valid/ready read side, occupancy and full flag.
module uart_rx_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_wr;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CNT_FULL);
  assign o_level = r_count;
  assign o_rdata = o_valid ? r_mem[r_rptr] : '0;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_pop = i_ready && o_valid;
  assign w_wr  = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5-8 data bits, none/even/odd parity,
// 1 or 2 stop bits, break detection and a buffered valid/ready output.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rx,
  input  logic [15:0]                   i_baud_div,
  input  logic [1:0]                    i_data_bits,
  input  logic [1:0]                    i_parity,
  input  logic                          i_stop2,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_frame_err,
  output logic                          o_parity_err,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_overrun,
  input  logic                          i_clr_ovr,
  output logic                          o_break,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int unsigned FW = DATA_W + 2;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rxs_prev;
  logic                   w_rxs;
  logic                   w_start;

  rx_state_t  r_state;
  rx_cfg_t    r_cfg;
  logic [15:0] r_cnt;
  logic [3:0]  r_bitn;
  logic [7:0]  r_shift;
  logic        r_ferr;
  logic        r_perr;
  logic        r_par_bit;
  logic        r_stop1_low;
  logic        r_break;
  logic        r_overrun;

  logic          w_half_hit;
  logic          w_full_hit;
  logic          w_par_en;
  logic          w_is_break;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic          w_full;
  logic [FW-1:0] w_wdata;
  logic [FW-1:0] w_rdata;

  // Synchroniser flops reset high so a released reset never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync     <= '1;
      r_rxs_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_rxs_prev <= w_rxs;
    end
  end

  assign w_rxs      = r_sync[SYNC_STAGES-1];
  assign w_start    = r_rxs_prev && !w_rxs;
  assign w_half_hit = (r_cnt == (i_baud_div >> 1));
  assign w_full_hit = (r_cnt == i_baud_div);
  assign w_par_en   = par_enabled(r_cfg.parity);
  assign w_is_break = (r_shift == '0) && (!w_par_en || !r_par_bit) && r_stop1_low;
  assign w_push     = (r_state == ST_PUSH);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cfg       <= '0;
      r_cnt       <= '0;
      r_bitn      <= '0;
      r_shift     <= '0;
      r_ferr      <= 1'b0;
      r_perr      <= 1'b0;
      r_par_bit   <= 1'b0;
      r_stop1_low <= 1'b0;
      r_break     <= 1'b0;
    end else begin
      r_break <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_START;
            r_cnt       <= '0;
            r_bitn      <= '0;
            r_shift     <= '0;
            r_ferr      <= 1'b0;
            r_perr      <= 1'b0;
            r_par_bit   <= 1'b0;
            r_stop1_low <= 1'b0;
            r_cfg.bits   <= {2'b00, i_data_bits} + 4'(BIT_MIN);
            r_cfg.parity <= i_parity;
            r_cfg.stop2  <= i_stop2;
          end
        end
        ST_START: begin
          if (w_half_hit) begin
            r_cnt <= '0;
            r_state <= w_rxs ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (w_full_hit) begin
            r_cnt                 <= '0;
            r_shift[r_bitn[2:0]]  <= w_rxs;
            r_bitn                <= r_bitn + 4'd1;
            if (r_bitn == r_cfg.bits - 4'd1) begin
              r_state <= w_par_en ? ST_PARITY : ST_STOP1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_PARITY: begin
          if (w_full_hit) begin
            r_cnt     <= '0;
            r_par_bit <= w_rxs;
            r_perr    <= (^r_shift) ^ w_rxs ^ (r_cfg.parity == PAR_ODD);
            r_state   <= ST_STOP1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_STOP1: begin
          if (w_full_hit) begin
            r_cnt       <= '0;
            r_ferr      <= !w_rxs;
            r_stop1_low <= !w_rxs;
            r_state     <= r_cfg.stop2 ? ST_STOP2 : ST_PUSH;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_STOP2: begin
          if (w_full_hit) begin
            r_cnt   <= '0;
            r_ferr  <= r_ferr | !w_rxs;
            r_state <= ST_PUSH;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_PUSH: begin
          if (w_is_break) begin
            r_break <= 1'b1;
            r_state <= ST_BRK_WAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BRK_WAIT: begin
          if (w_rxs) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_wdata          = '0;
    w_wdata[9:2]     = r_shift;
    w_wdata[1]       = r_ferr;
    w_wdata[0]       = r_perr;
  end

  assign w_pop = w_valid && i_ready;

  // A same-cycle pop makes room, so only an unserviced full FIFO drops the word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overrun <= 1'b1;
    end else if (i_clr_ovr) begin
      r_overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_ready (i_ready),
    .o_valid (w_valid),
    .o_rdata (w_rdata),
    .o_level (o_level),
    .o_full  (w_full)
  );

  assign o_data       = w_rdata[FW-1:2];
  assign o_frame_err  = w_rdata[1];
  assign o_parity_err = w_rdata[0];
  assign o_valid      = w_valid;
  assign o_overrun    = r_overrun;
  assign o_break      = r_break;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed, table-driven bench for uart_rx_cfg at i_baud_div = 15.
module tb_uart_rx_cfg;

  localparam int BIT_CLKS = 16;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_rx;
  logic [15:0] i_baud_div;
  logic [1:0]  i_data_bits;
  logic [1:0]  i_parity;
  logic        i_stop2;
  logic [7:0]  o_data;
  logic        o_frame_err;
  logic        o_parity_err;
  logic        o_valid;
  logic        i_ready;
  logic        o_overrun;
  logic        i_clr_ovr;
  logic        o_break;
  logic        o_busy;
  logic [2:0]  o_level;

  int checks = 0;
  int errors = 0;
  int brk_cnt = 0;

  uart_rx_cfg #(
    .DATA_W      (8),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rx         (i_rx),
    .i_baud_div   (i_baud_div),
    .i_data_bits  (i_data_bits),
    .i_parity     (i_parity),
    .i_stop2      (i_stop2),
    .o_data       (o_data),
    .o_frame_err  (o_frame_err),
    .o_parity_err (o_parity_err),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_overrun    (o_overrun),
    .i_clr_ovr    (i_clr_ovr),
    .o_break      (o_break),
    .o_busy       (o_busy),
    .o_level      (o_level)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_break) brk_cnt++;

  initial begin
    #3ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] d;
    logic [1:0] bits;
    logic [1:0] par;
    logic       pb;
    logic       s1;
    logic       s2;
    logic       stop2;
    logic [7:0] ed;
    logic       ef;
    logic       ep;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    i_rx = b;
    repeat (BIT_CLKS) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                            input logic pb, input logic s1, input logic s2, input logic two);
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    if (pen) send_bit(pb);
    send_bit(s1);
    if (two) send_bit(s2);
  endtask

  task automatic idle(input int nbits);
    i_rx = 1'b1;
    repeat (nbits * BIT_CLKS) @(negedge i_clk);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!o_valid && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    check({name, "_valid"}, 32'(o_valid), 32'd1);
  endtask

  task automatic pop();
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] bits, input logic [1:0] par, input logic two);
    i_data_bits = bits;
    i_parity    = par;
    i_stop2     = two;
  endtask

  initial begin
    int brk0;
    logic [7:0] d;

    vecs[0]  = '{8'hA5, 2'd3, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{8'h41, 2'd2, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[2]  = '{8'h41, 2'd2, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1};
    vecs[3]  = '{8'h03, 2'd3, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[4]  = '{8'h03, 2'd3, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1};
    vecs[5]  = '{8'h3F, 2'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b0};
    vecs[6]  = '{8'h5A, 2'd3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};
    vecs[7]  = '{8'h81, 2'd3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0};
    vecs[8]  = '{8'h2A, 2'd1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b0};
    vecs[9]  = '{8'hC3, 2'd3, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 2'd3, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};

    i_rst_n = 1'b0; i_rx = 1'b1; i_baud_div = 16'd15; i_ready = 1'b0; i_clr_ovr = 1'b0;
    set_cfg(2'd3, 2'b00, 1'b0);
    repeat (3) @(negedge i_clk);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_level", 32'(o_level), 0);
    check("rst_ovr", 32'(o_overrun), 0);
    check("rst_errs", {30'd0, o_frame_err, o_parity_err}, 0);
    i_rst_n = 1'b1;
    idle(2);
    check("idle_busy", 32'(o_busy), 0);

    brk0 = brk_cnt;
    for (int v = 0; v < 11; v++) begin
      set_cfg(vecs[v].bits, vecs[v].par, vecs[v].stop2);
      send_frame(vecs[v].d, int'(vecs[v].bits) + 5,
                 (vecs[v].par == 2'b01) || (vecs[v].par == 2'b10),
                 vecs[v].pb, vecs[v].s1, vecs[v].s2, vecs[v].stop2);
      idle(2);
      wait_valid($sformatf("v%0d", v));
      check($sformatf("v%0d_data", v), 32'(o_data), 32'(vecs[v].ed));
      check($sformatf("v%0d_ferr", v), 32'(o_frame_err), 32'(vecs[v].ef));
      check($sformatf("v%0d_perr", v), 32'(o_parity_err), 32'(vecs[v].ep));
      pop();
      check($sformatf("v%0d_level", v), 32'(o_level), 0);
    end
    check("table_nobreak", 32'(brk_cnt - brk0), 0);

    // False start: 3-clock glitch
    @(negedge i_clk);
    i_rx = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rx = 1'b1;
    check("fs_busy_hi", 32'(o_busy), 1);
    repeat (30) @(negedge i_clk);
    check("fs_busy_lo", 32'(o_busy), 0);
    check("fs_valid", 32'(o_valid), 0);

    // Break: 20 bit periods low
    set_cfg(2'd3, 2'b00, 1'b0);
    brk0 = brk_cnt;
    i_rx = 1'b0;
    repeat (20 * BIT_CLKS) @(negedge i_clk);
    check("brk_pulses", 32'(brk_cnt - brk0), 1);
    check("brk_valid", 32'(o_valid), 1);
    check("brk_data", 32'(o_data), 0);
    check("brk_ferr", 32'(o_frame_err), 1);
    check("brk_perr", 32'(o_parity_err), 0);
    check("brk_busy", 32'(o_busy), 1);
    i_rx = 1'b1;
    repeat (8) @(negedge i_clk);
    check("brk_busy_lo", 32'(o_busy), 0);
    pop();
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    wait_valid("after_brk");
    check("after_brk_data", 32'(o_data), 32'h55);
    check("after_brk_ferr", 32'(o_frame_err), 0);
    pop();

    // Overrun: five back-to-back 8O2 frames into a 4-deep FIFO
    set_cfg(2'd3, 2'b10, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      d = 8'(k);
      send_frame(d, 8, 1'b1, ~^d, 1'b1, 1'b1, 1'b1);
    end
    idle(2);
    check("ovr_level", 32'(o_level), 4);
    check("ovr_flag", 32'(o_overrun), 1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovr_drain%0d", k), 32'(o_data), 32'(k));
      check($sformatf("ovr_perr%0d", k), 32'(o_parity_err), 0);
      pop();
    end
    check("ovr_empty", 32'(o_valid), 0);
    check("ovr_sticky", 32'(o_overrun), 1);
    i_clr_ovr = 1'b1;
    @(negedge i_clk);
    i_clr_ovr = 1'b0;
    check("ovr_clr", 32'(o_overrun), 0);

    // Reset during data bit 3, with a word already queued
    set_cfg(2'd3, 2'b00, 1'b0);
    send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("mr_pre_level", 32'(o_level), 1);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    i_rx = 1'b1;
    repeat (8) @(negedge i_clk);
    check("mr_busy_pre", 32'(o_busy), 1);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("mr_valid", 32'(o_valid), 0);
    check("mr_level", 32'(o_level), 0);
    check("mr_data", 32'(o_data), 0);
    check("mr_busy", 32'(o_busy), 0);
    i_rst_n = 1'b1;
    idle(20);
    check("mr_nopush", 32'(o_valid), 0);
    check("mr_idle", 32'(o_busy), 0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    wait_valid("mr_next");
    check("mr_next_data", 32'(o_data), 32'h3C);
    check("mr_next_errs", {30'd0, o_frame_err, o_parity_err}, 0);
    pop();
    check("mr_next_level", 32'(o_level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
